// File: rtl/store_rmw_unit_pkg.sv
// Shared definitions for the store read-modify-write unit: request type
// codes, FSM state encoding, word-align mask and the request legality rule.
package store_rmw_unit_pkg;

    typedef enum logic [1:0] {
        ST_SW  = 2'b00,
        ST_SH  = 2'b01,
        ST_SB  = 2'b10,
        ST_ILL = 2'b11
    } store_type_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WAIT = 2'd2,
        S_WR   = 2'd3
    } state_e;

    localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

    // A request is rejected when its type is illegal or its address is not
    // naturally aligned for its access size.
    function automatic logic is_bad_req(input logic [1:0] req_type, input logic [1:0] lane);
        return (req_type == ST_ILL)
            || ((req_type == ST_SH) && lane[0])
            || ((req_type == ST_SW) && (lane != 2'b00));
    endfunction

endpackage

// File: rtl/store_rmw_unit_lane_merge.sv
// Splices narrowed store data into an existing memory word.
// sb replaces one byte lane, sh one half-word lane, sw the whole word.
module store_lane_merge
    import store_rmw_unit_pkg::*;
(
    input  logic [31:0] old_word_i,
    input  logic [31:0] data_i,
    input  logic [1:0]  type_i,
    input  logic [1:0]  lane_i,
    output logic [31:0] merged_o
);

    // Lane selection from the low address bits; unused data bits are dropped.
    always_comb begin
        merged_o = old_word_i;
        unique case (type_i)
            ST_SW: merged_o = data_i;
            ST_SH: begin
                if (lane_i[1]) merged_o[31:16] = data_i[15:0];
                else           merged_o[15:0]  = data_i[15:0];
            end
            ST_SB: begin
                unique case (lane_i)
                    2'd0:    merged_o[7:0]   = data_i[7:0];
                    2'd1:    merged_o[15:8]  = data_i[7:0];
                    2'd2:    merged_o[23:16] = data_i[7:0];
                    default: merged_o[31:24] = data_i[7:0];
                endcase
            end
            default: merged_o = old_word_i;
        endcase
    end

endmodule

// File: rtl/store_rmw_unit.sv
// Store-side read-modify-write unit in front of a word-only data memory.
// sw writes directly; sb/sh read the word, merge the lane and write it back.
// Misaligned or illegal requests raise misalign_err and never touch memory.
//
// state  | meaning
// IDLE   | ready for a request; rejected requests stay here
// RD     | one-cycle read strobe to the memory
// WAIT   | counting read latency; captures merged word when data is valid
// WR     | one-cycle write strobe with done pulse
module store_rmw_unit
    import store_rmw_unit_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_type,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] mem_addr,
    output logic        mem_rd_en,
    input  logic [31:0] mem_rdata,
    output logic        mem_wr_en,
    output logic [31:0] mem_wdata,
    output logic        done,
    output logic        misalign_err
);

    localparam logic [2:0] LAT = 3'(RD_LATENCY);

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [1:0]  type_q, type_d;
    logic [31:0] word_q, word_d;
    logic        err_q, err_d;
    logic [31:0] merged_word;
    logic        accept;

    assign accept = req_valid & req_ready;

    store_lane_merge u_merge (
        .old_word_i (mem_rdata),
        .data_i     (data_q),
        .type_i     (type_q),
        .lane_i     (addr_q[1:0]),
        .merged_o   (merged_word)
    );

    // State and request registers; reset drops any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            addr_q  <= 32'd0;
            data_q  <= 32'd0;
            type_q  <= 2'd0;
            word_q  <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            type_q  <= type_d;
            word_q  <= word_d;
            err_q   <= err_d;
        end
    end

    // Next-state: latch on accept, count read latency, capture merged word.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        type_d  = type_q;
        word_d  = word_q;
        err_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d = req_addr;
                    data_d = req_wdata;
                    type_d = req_type;
                    word_d = req_wdata;
                    if (is_bad_req(req_type, req_addr[1:0])) begin
                        err_d = 1'b1;
                    end else if (req_type == ST_SW) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                state_d = S_WAIT;
                cnt_d   = 3'd1;
            end
            S_WAIT: begin
                if (cnt_q == LAT) begin
                    word_d  = merged_word;
                    state_d = S_WR;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_WR: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state; everything is forced low while in reset.
    always_comb begin
        req_ready    = (state_q == S_IDLE) && !reset;
        mem_addr     = 32'd0;
        mem_rd_en    = 1'b0;
        mem_wr_en    = 1'b0;
        mem_wdata    = 32'd0;
        done         = 1'b0;
        misalign_err = 1'b0;
        if (!reset) begin
            misalign_err = err_q;
            if (state_q != S_IDLE) mem_addr = addr_q & WORD_ALIGN_MASK;
            mem_rd_en = (state_q == S_RD);
            if (state_q == S_WR) begin
                mem_wr_en = 1'b1;
                mem_wdata = word_q;
                done      = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_store_rmw_unit.sv
// Bench for store_rmw_unit: sparse memory responder, cycle-level reference
// model built from operation timing, directed scenarios and random traffic.
module tb_store_rmw_unit;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_type;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] mem_addr;
    logic        mem_rd_en;
    logic [31:0] mem_rdata;
    logic        mem_wr_en;
    logic [31:0] mem_wdata;
    logic        done;
    logic        misalign_err;

    store_rmw_unit #(.RD_LATENCY(LAT)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_type     (req_type),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .mem_addr     (mem_addr),
        .mem_rd_en    (mem_rd_en),
        .mem_rdata    (mem_rdata),
        .mem_wr_en    (mem_wr_en),
        .mem_wdata    (mem_wdata),
        .done         (done),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Memory seen by the DUT, and the memory the model expects.
    logic [31:0] mem  [logic [31:0]];
    logic [31:0] emem [logic [31:0]];

    typedef struct {
        int          due;
        logic [31:0] a;
    } rd_t;
    rd_t rdq[$];

    // Model: current operation and cycles elapsed since its accept.
    bit          m_active = 0;
    int          m_t      = 0;
    int          m_kind   = 0;   // 0 word write, 1 sub-word rmw, 2 rejected
    logic [31:0] m_addr   = 0;
    logic [31:0] m_data   = 0;
    logic [1:0]  m_type   = 0;
    bit          e_ready  = 0;
    bit          e_wr     = 0;
    logic [31:0] e_waddr  = 0;
    logic [31:0] e_wdata  = 0;

    function logic [31:0] dflt(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
    endfunction

    function logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : dflt(a);
    endfunction

    function logic [31:0] emem_rd(input logic [31:0] a);
        return emem.exists(a) ? emem[a] : dflt(a);
    endfunction

    function automatic logic [31:0] model_merge(input logic [31:0] old, input logic [1:0] t,
                                                input logic [31:0] a, input logic [31:0] d);
        int          sh;
        logic [31:0] mask;
        if (t == 2'b10) begin
            sh   = 8 * int'(a[1:0]);
            mask = 32'h0000_00FF << sh;
            return (old & ~mask) | ((d & 32'h0000_00FF) << sh);
        end
        if (t == 2'b01) begin
            sh   = 16 * int'(a[1]);
            mask = 32'h0000_FFFF << sh;
            return (old & ~mask) | ((d & 32'h0000_FFFF) << sh);
        end
        return d;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare process: expected outputs for this cycle versus the DUT.
    initial begin
        int  wr_cyc;
        bit  busy, e_rd, e_err;
        forever begin
            @(negedge clk);
            wr_cyc  = (m_kind == 0) ? 1 : 2 + LAT;
            busy    = m_active && (m_kind != 2) && (m_t <= wr_cyc);
            e_rd    = !reset && busy && (m_kind == 1) && (m_t == 1);
            e_wr    = !reset && busy && (m_t == wr_cyc);
            e_err   = !reset && m_active && (m_kind == 2) && (m_t == 1);
            e_ready = !reset && !busy;
            e_waddr = m_addr & 32'hFFFF_FFFC;
            e_wdata = !e_wr ? 32'd0 :
                      (m_kind == 0) ? m_data : model_merge(emem_rd(e_waddr), m_type, m_addr, m_data);
            check("req_ready",    {31'd0, req_ready},    {31'd0, e_ready});
            check("mem_rd_en",    {31'd0, mem_rd_en},    {31'd0, e_rd});
            check("mem_wr_en",    {31'd0, mem_wr_en},    {31'd0, e_wr});
            check("done",         {31'd0, done},         {31'd0, e_wr});
            check("misalign_err", {31'd0, misalign_err}, {31'd0, e_err});
            check("mem_addr",     mem_addr, (!reset && busy) ? e_waddr : 32'd0);
            check("mem_wdata",    mem_wdata, e_wdata);
            if (mem_wr_en) mem[mem_addr] = mem_wdata;
            if (mem_rd_en) rdq.push_back('{due: cyc + LAT, a: mem_addr});
        end
    end

    // Model update at each edge, then the memory read-data responder.
    initial begin
        bit bad;
        mem_rdata = 32'd0;
        forever begin
            @(posedge clk);
            cyc++;
            if (e_wr) emem[e_waddr] = e_wdata;
            if (reset) begin
                m_active = 0;
            end else begin
                if (m_active) begin
                    m_t++;
                    if (m_t > ((m_kind == 1) ? 2 + LAT : 1)) m_active = 0;
                end
                if (req_valid && e_ready) begin
                    bad = (req_type == 2'b11) || (req_type == 2'b01 && req_addr[0])
                          || (req_type == 2'b00 && req_addr[1:0] != 2'b00);
                    m_kind   = bad ? 2 : (req_type == 2'b00) ? 0 : 1;
                    m_active = 1;
                    m_t      = 1;
                    m_addr   = req_addr;
                    m_data   = req_wdata;
                    m_type   = req_type;
                end
            end
            #1;
            while (rdq.size() > 0 && rdq[0].due < cyc) void'(rdq.pop_front());
            if (rdq.size() > 0 && rdq[0].due == cyc) begin
                mem_rdata = mem_rd(rdq[0].a);
                void'(rdq.pop_front());
            end else begin
                mem_rdata = $urandom;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    task automatic preload(input logic [31:0] a, input logic [31:0] v);
        mem[a]  = v;
        emem[a] = v;
    endtask

    // One request, then observe a fixed window for strobes (bounded wait).
    task automatic op(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d,
                      output int wk, output int rk, output int ek, output logic [31:0] wd);
        @(posedge clk); #2;
        req_valid = 1'b1; req_type = t; req_addr = a; req_wdata = d;
        @(posedge clk); #2;
        req_valid = 1'b0; req_wdata = $urandom;
        wk = 0; rk = 0; ek = 0; wd = 32'd0;
        for (int k = 1; k <= 2 + LAT + 3; k++) begin
            @(negedge clk);
            if (done && wk == 0) begin wk = k; wd = mem_wdata; end
            if (mem_rd_en && rk == 0) rk = k;
            if (misalign_err && ek == 0) ek = k;
            @(posedge clk); #2;
        end
    endtask

    initial begin
        int          wk, rk, ek, ndone, d1, d2;
        logic [31:0] wd, w1, w2;
        logic [31:0] sb_exp [4];
        sb_exp[0] = 32'h1122_33AB; sb_exp[1] = 32'h1122_AB44;
        sb_exp[2] = 32'h11AB_3344; sb_exp[3] = 32'hAB22_3344;

        reset = 1'b1; req_valid = 1'b0; req_type = 2'd0; req_addr = 32'd0; req_wdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #2;
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", {31'd0, req_ready}, 32'd1);

        // sw direct write
        op(2'b00, 32'h10, 32'hDEAD_BEEF, wk, rk, ek, wd);
        check("sw_lat", wk, 1);
        check("sw_wdata", wd, 32'hDEAD_BEEF);
        check("sw_no_rd", rk, 0);
        check("sw_mem", mem_rd(32'h10), 32'hDEAD_BEEF);

        // sb in each byte lane
        for (int l = 0; l < 4; l++) begin
            preload(32'h20, 32'h1122_3344);
            op(2'b10, 32'h20 + l, 32'hFFFF_FFAB, wk, rk, ek, wd);
            check("sb_rd_lat", rk, 1);
            check("sb_wr_lat", wk, 2 + LAT);
            check("sb_wdata", wd, sb_exp[l]);
        end

        // sh upper half
        preload(32'h40, 32'hCAFE_F00D);
        op(2'b01, 32'h42, 32'hAAAA_1234, wk, rk, ek, wd);
        check("sh_rd_lat", rk, 1);
        check("sh_wr_lat", wk, 2 + LAT);
        check("sh_wdata", wd, 32'h1234_F00D);

        // rejected requests
        op(2'b01, 32'h5, 32'h1, wk, rk, ek, wd);
        check("err_sh", ek, 1); check("err_sh_nowr", wk, 0); check("err_sh_nord", rk, 0);
        op(2'b00, 32'h6, 32'h2, wk, rk, ek, wd);
        check("err_sw", ek, 1); check("err_sw_nowr", wk, 0);
        op(2'b11, 32'h30, 32'h3, wk, rk, ek, wd);
        check("err_ill", ek, 1); check("err_ill_nowr", wk, 0);

        // rejected request immediately followed by a valid sw
        @(posedge clk); #2;
        req_valid = 1'b1; req_type = 2'b01; req_addr = 32'h5;
        @(posedge clk); #2;
        req_type = 2'b00; req_addr = 32'h50; req_wdata = 32'h0BAD_CAFE;
        @(negedge clk);
        check("b2b_err", {31'd0, misalign_err}, 32'd1);
        check("b2b_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #2;
        req_valid = 1'b0;
        @(negedge clk);
        check("b2b_done", {31'd0, done}, 32'd1);
        check("b2b_wdata", mem_wdata, 32'h0BAD_CAFE);
        repeat (3) @(posedge clk);
        #2;

        // reset while waiting for read data
        req_valid = 1'b1; req_type = 2'b10; req_addr = 32'h61; req_wdata = 32'h99;
        @(posedge clk); #2;
        req_valid = 1'b0;
        @(posedge clk); #2;
        reset = 1'b1;
        @(negedge clk);
        check("rst_wait_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #2;
        reset = 1'b0;
        @(negedge clk);
        check("rst_after_ready", {31'd0, req_ready}, 32'd1);
        ndone = 0;
        for (int k = 0; k < 2 + LAT + 2; k++) begin
            @(negedge clk);
            if (done || mem_wr_en) ndone++;
        end
        check("rst_no_write", ndone, 0);
        op(2'b00, 32'h64, 32'h55AA_55AA, wk, rk, ek, wd);
        check("rst_then_sw", wd, 32'h55AA_55AA);
        check("rst_then_sw_lat", wk, 1);

        // request held valid through a busy sb, then an sw
        @(posedge clk); #2;
        req_valid = 1'b1; req_type = 2'b10; req_addr = 32'h71; req_wdata = 32'h77;
        @(posedge clk); #2;
        req_type = 2'b00; req_addr = 32'h74; req_wdata = 32'h1234_5678;
        ndone = 0; d1 = 0; d2 = 0; w1 = 0; w2 = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k <= 2 + LAT) check("hold_busy_ready", {31'd0, req_ready}, 32'd0);
            if (done) begin
                ndone++;
                if (ndone == 1) begin d1 = k; w1 = mem_wdata; end
                else begin d2 = k; w2 = mem_wdata; end
            end
            @(posedge clk); #2;
            if (k == 2 + LAT + 1) req_valid = 1'b0;
        end
        check("hold_ndone", ndone, 2);
        check("hold_d1", d1, 2 + LAT);
        check("hold_d2", d2, 2 + LAT + 2);
        check("hold_w1", w1, (dflt(32'h70) & 32'hFFFF_00FF) | 32'h0000_7700);
        check("hold_w2", w2, 32'h1234_5678);

        // random traffic including occasional resets
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #2;
            reset     = ($urandom_range(0, 99) == 0);
            req_valid = ($urandom_range(0, 2) != 0);
            req_type  = 2'($urandom);
            req_addr  = 32'h100 + $urandom_range(0, 31);
            req_wdata = $urandom;
        end
        @(posedge clk); #2;
        reset = 1'b0; req_valid = 1'b0;
        repeat (2 + LAT + 4) @(posedge clk);
        @(negedge clk);
        foreach (emem[a]) check("final_mem", mem_rd(a), emem[a]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
